// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception/interrupt request controller.
//
// Collects synchronous exceptions from the decoder (illegal, ecall, ebreak)
// and level interrupts from the platform, prioritises them and presents one
// request at a time on the exc_req_o/exc_ack_i handshake.  On acknowledge the
// winning cause is latched for mcause and interrupts stay blocked until eret.
//
// Build option:
//   EXC_CTRL_IRQ_EN  defined   -> full interrupt path (irq_q, id_q, IRQ_REQ).
//                    undefined -> synchronous exceptions only; irq_i,
//                                 irq_mask_i and irq_enable_i are ignored.
//
// Ports:
//   clk            core clock
//   rst            synchronous active-high reset
//   irq_i          level interrupt lines (asynchronous to the pipeline)
//   irq_mask_i     per-line interrupt enable
//   irq_enable_i   global interrupt enable
//   is_decoding_i  ID stage holds a valid instruction (qualifies sync inputs)
//   illegal_insn_i decoder flags: illegal instruction
//   ecall_insn_i   decoder flags: ecall
//   ebreak_insn_i  decoder flags: ebreak
//   eret_i         eret retired, leave the handler
//   exc_req_o      request to the main controller
//   exc_ack_i      controller accepts the request
//   exc_cause_o    latched cause: bit5 interrupt flag, bits4:0 code
//   save_cause_o   one-cycle pulse after an accepted request
//   in_handler_o   handler active, interrupts blocked
module exc_ctrl #(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               irq_enable_i,
    input  logic               is_decoding_i,
    input  logic               illegal_insn_i,
    input  logic               ecall_insn_i,
    input  logic               ebreak_insn_i,
    input  logic               eret_i,
    output logic               exc_req_o,
    input  logic               exc_ack_i,
    output logic [5:0]         exc_cause_o,
    output logic               save_cause_o,
    output logic               in_handler_o
);

`ifdef EXC_CTRL_IRQ_EN
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IRQ_REQ    = 2'd1,
        IN_HANDLER = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE       = 1'b0,
        IN_HANDLER = 1'b1
    } state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       sync;
    logic [5:0] sync_cause;
    logic [5:0] cur_cause;
    logic       ack_ok;

    // Synchronous exceptions are never stored: they exist only while the
    // offending instruction sits in ID.
    always_comb begin
        sync = is_decoding_i & (illegal_insn_i | ecall_insn_i | ebreak_insn_i);
        if (illegal_insn_i)    sync_cause = 6'h02;
        else if (ecall_insn_i) sync_cause = 6'h0B;
        else                   sync_cause = 6'h03;
    end

`ifdef EXC_CTRL_IRQ_EN
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend;
    logic               irq_any;
    logic [4:0]         irq_id;
    logic [4:0]         id_q;
    logic [4:0]         id_nxt;

    assign pend    = irq_q & irq_mask_i & {NUM_IRQ{irq_enable_i}};
    assign irq_any = |pend;

    // Scan from the top down so the lowest pending index is written last.
    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) irq_id = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= '0;
            id_q  <= '0;
        end else begin
            irq_q <= irq_i;
            id_q  <= id_nxt;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{irq_i, irq_mask_i, irq_enable_i};
`endif

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        exc_req_o = 1'b0;
        cur_cause = sync_cause;
`ifdef EXC_CTRL_IRQ_EN
        id_nxt    = id_q;
`endif
        case (state)
            IDLE: begin
`ifdef EXC_CTRL_IRQ_EN
                exc_req_o = sync | irq_any;
                if (!sync) cur_cause = {1'b1, irq_id};
                if (exc_ack_i && exc_req_o) begin
                    state_nxt = IN_HANDLER;
                end else if (irq_any) begin
                    // Make the interrupt sticky so the request survives the
                    // line or mask dropping before the ack arrives.
                    state_nxt = IRQ_REQ;
                    id_nxt    = irq_id;
                end
`else
                exc_req_o = sync;
                if (exc_ack_i && sync) state_nxt = IN_HANDLER;
`endif
            end
`ifdef EXC_CTRL_IRQ_EN
            IRQ_REQ: begin
                exc_req_o = 1'b1;
                if (!sync) cur_cause = {1'b1, id_q};
                if (exc_ack_i) begin
                    // If a sync exception took the ack, the interrupt is
                    // forgotten and re-sampled from irq_q after eret.
                    state_nxt = IN_HANDLER;
                    id_nxt    = '0;
                end
            end
`endif
            IN_HANDLER: begin
                // Interrupts are blocked; only nested faults are requested.
                exc_req_o = sync;
                if (!(exc_ack_i && sync) && eret_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ack_ok = exc_ack_i & exc_req_o;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            exc_cause_o  <= '0;
            save_cause_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            save_cause_o <= ack_ok;
            if (ack_ok) exc_cause_o <= cur_cause;
        end
    end

    assign in_handler_o = (state == IN_HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios with fixed expected
// values, then randomized traffic compared against a behavioural model.
module tb_exc_ctrl;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic [N-1:0] mask;
    logic         en;
    logic         dec;
    logic         ill;
    logic         ec;
    logic         eb;
    logic         eret;
    logic         ack;
    logic         exc_req_o;
    logic [5:0]   exc_cause_o;
    logic         save_cause_o;
    logic         in_handler_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.NUM_IRQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq),
        .irq_mask_i    (mask),
        .irq_enable_i  (en),
        .is_decoding_i (dec),
        .illegal_insn_i(ill),
        .ecall_insn_i  (ec),
        .ebreak_insn_i (eb),
        .eret_i        (eret),
        .exc_req_o     (exc_req_o),
        .exc_ack_i     (ack),
        .exc_cause_o   (exc_cause_o),
        .save_cause_o  (save_cause_o),
        .in_handler_o  (in_handler_o)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read then.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq = '0; mask = '1; en = 1'b1;
        dec = 1'b0; ill = 1'b0; ec = 1'b0; eb = 1'b0;
        eret = 1'b0; ack = 1'b0;
    endtask

    task automatic leave_handler();
        clear_inputs();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    bit           m_handler;
    bit           m_sticky;
    logic [4:0]   m_id;
    logic [N-1:0] m_irq_seen;
    logic [5:0]   m_cause;
    bit           m_save;
    bit           e_req;
    logic [5:0]   e_cur;
    int           e_lo;

    function automatic int lowest_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_handler = 0; m_sticky = 0; m_id = '0; m_irq_seen = '0;
        m_cause = '0; m_save = 0;
    endtask

    task automatic model_predict();
        bit           s;
        logic [5:0]   sc;
        logic [N-1:0] pend;
        s  = dec && (ill || ec || eb);
        sc = ill ? 6'h02 : (ec ? 6'h0B : 6'h03);
`ifdef EXC_CTRL_IRQ_EN
        pend = m_irq_seen & mask & {N{en}};
`else
        pend = '0;
`endif
        e_lo = lowest_set(pend);
        if (m_handler) begin
            e_req = s; e_cur = sc;
        end else if (m_sticky) begin
            e_req = 1; e_cur = s ? sc : {1'b1, m_id};
        end else begin
            e_req = s || (e_lo >= 0);
            e_cur = s ? sc : {1'b1, 5'(e_lo)};
        end
    endtask

    task automatic model_advance();
        bit accepted;
        if (rst) begin
            model_reset();
        end else begin
            accepted = ack && e_req;
            m_save   = accepted;
            if (accepted) m_cause = e_cur;
            if (m_handler) begin
                if (!accepted && eret) m_handler = 0;
            end else if (accepted) begin
                m_handler = 1; m_sticky = 0;
            end else if (!m_sticky && e_lo >= 0) begin
                m_sticky = 1; m_id = 5'(e_lo);
            end
            m_irq_seen = irq;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", exc_req_o); end
        vectors++; if (exc_cause_o !== 6'h00) begin miscompares++; $display("FAIL reset_cause got %h want 00", exc_cause_o); end
        vectors++; if (save_cause_o !== 1'b0) begin miscompares++; $display("FAIL reset_save got %b want 0", save_cause_o); end
        vectors++; if (in_handler_o !== 1'b0) begin miscompares++; $display("FAIL reset_handler got %b want 0", in_handler_o); end
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        clear_inputs();
        dec = 1; ill = 0;
        #1;
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL no_sync_req got %b want 0", exc_req_o); end
        dec = 0; ill = 1;
        #1;
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL undecoded_req got %b want 0", exc_req_o); end
        dec = 1; ack = 1;
        #1;
        vectors++; if (exc_req_o !== 1'b1) begin miscompares++; $display("FAIL illegal_req got %b want 1", exc_req_o); end
        tick();
        clear_inputs();
        vectors++; if (exc_cause_o !== 6'h02) begin miscompares++; $display("FAIL illegal_cause got %h want 02", exc_cause_o); end
        vectors++; if (save_cause_o !== 1'b1) begin miscompares++; $display("FAIL illegal_save got %b want 1", save_cause_o); end
        vectors++; if (in_handler_o !== 1'b1) begin miscompares++; $display("FAIL illegal_handler got %b want 1", in_handler_o); end
        tick();
        vectors++; if (save_cause_o !== 1'b0) begin miscompares++; $display("FAIL save_width got %b want 0", save_cause_o); end
        leave_handler();
        vectors++; if (in_handler_o !== 1'b0) begin miscompares++; $display("FAIL eret_exit got %b want 0", in_handler_o); end
    endtask

    task automatic test_ack_ignored();
        clear_inputs();
        ack = 1;
        tick();
        ack = 0;
        vectors++; if (save_cause_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack_save got %b want 0", save_cause_o); end
        vectors++; if (in_handler_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack_handler got %b want 0", in_handler_o); end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        dec = 1; ill = 1; ec = 1; eb = 1; ack = 1;
        tick();
        vectors++; if (exc_cause_o !== 6'h02) begin miscompares++; $display("FAIL all_sync_cause got %h want 02", exc_cause_o); end
        // Nested ecall+ebreak acked together with eret: ack wins.
        ill = 0; eret = 1;
        tick();
        clear_inputs();
        vectors++; if (exc_cause_o !== 6'h0B) begin miscompares++; $display("FAIL nested_cause got %h want 0b", exc_cause_o); end
        vectors++; if (in_handler_o !== 1'b1) begin miscompares++; $display("FAIL ack_beats_eret got %b want 1", in_handler_o); end
        dec = 1; eb = 1; ack = 1;
        tick();
        vectors++; if (exc_cause_o !== 6'h03) begin miscompares++; $display("FAIL ebreak_cause got %h want 03", exc_cause_o); end
        leave_handler();
    endtask

`ifdef EXC_CTRL_IRQ_EN
    task automatic test_irq_priority();
        clear_inputs();
        irq = 32'h0000_0030;
        #1;
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL irq_latency0 got %b want 0", exc_req_o); end
        tick();
        irq = '0;
        #1;
        vectors++; if (exc_req_o !== 1'b1) begin miscompares++; $display("FAIL irq_latency1 got %b want 1", exc_req_o); end
        tick();
        vectors++; if (exc_req_o !== 1'b1) begin miscompares++; $display("FAIL irq_sticky got %b want 1", exc_req_o); end
        tick();
        ack = 1;
        tick();
        ack = 0;
        vectors++; if (exc_cause_o !== 6'h24) begin miscompares++; $display("FAIL irq_cause got %h want 24", exc_cause_o); end
        vectors++; if (save_cause_o !== 1'b1) begin miscompares++; $display("FAIL irq_save got %b want 1", save_cause_o); end
        leave_handler();
    endtask

    task automatic test_preempt();
        clear_inputs();
        irq = 32'h0000_0010;
        tick();
        tick();
        dec = 1; ec = 1; ack = 1;
        tick();
        dec = 0; ec = 0; ack = 0;
        vectors++; if (exc_cause_o !== 6'h0B) begin miscompares++; $display("FAIL preempt_cause got %h want 0b", exc_cause_o); end
        eret = 1;
        tick();
        eret = 0;
        #1;
        vectors++; if (exc_req_o !== 1'b1) begin miscompares++; $display("FAIL resample_req got %b want 1", exc_req_o); end
        ack = 1;
        tick();
        ack = 0;
        vectors++; if (exc_cause_o !== 6'h24) begin miscompares++; $display("FAIL resample_cause got %h want 24", exc_cause_o); end
        leave_handler();
    endtask

    task automatic test_blocking();
        clear_inputs();
        dec = 1; ill = 1; ack = 1;
        tick();
        clear_inputs();
        irq = 32'h0000_0001;
        tick();
        tick();
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL blocked_req got %b want 0", exc_req_o); end
        eret = 1;
        tick();
        eret = 0;
        #1;
        vectors++; if (exc_req_o !== 1'b1) begin miscompares++; $display("FAIL unblocked_req got %b want 1", exc_req_o); end
        ack = 1;
        tick();
        ack = 0;
        vectors++; if (exc_cause_o !== 6'h20) begin miscompares++; $display("FAIL irq0_cause got %h want 20", exc_cause_o); end
        leave_handler();
    endtask

    task automatic test_enable_off();
        clear_inputs();
        en = 0; irq = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL gie_off_req cyc %0d got %b want 0", i, exc_req_o); end
        end
        irq = '0;
        tick();
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        irq = 32'h0000_0010;
        tick();
        tick();
        irq = '0;
        rst = 1; ack = 1;
        tick();
        rst = 0; ack = 0;
        vectors++; if (save_cause_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_save got %b want 0", save_cause_o); end
        vectors++; if (exc_cause_o !== 6'h00) begin miscompares++; $display("FAIL rst_mid_cause got %h want 00", exc_cause_o); end
        vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req got %b want 0", exc_req_o); end
        vectors++; if (in_handler_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_handler got %b want 0", in_handler_o); end
    endtask
`else
    task automatic test_irq_ignored();
        clear_inputs();
        irq = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (exc_req_o !== 1'b0) begin miscompares++; $display("FAIL irq_off_req cyc %0d got %b want 0", i, exc_req_o); end
        end
        clear_inputs();
    endtask
`endif

    task automatic test_random();
        clear_inputs();
        rst = 1;
        tick();
        model_reset();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            dec  = $urandom_range(0, 1) == 1;
            ill  = $urandom_range(0, 9) == 0;
            ec   = $urandom_range(0, 9) == 0;
            eb   = $urandom_range(0, 9) == 0;
            ack  = $urandom_range(0, 2) == 0;
            eret = $urandom_range(0, 5) == 0;
            en   = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) irq = '0;
            mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            #1;
            model_predict();
            vectors++; if (exc_req_o !== e_req) begin miscompares++; $display("FAIL rnd_req cyc %0d got %b want %b", c, exc_req_o, e_req); end
            tick();
            model_advance();
            vectors++; if (exc_cause_o !== m_cause) begin miscompares++; $display("FAIL rnd_cause cyc %0d got %h want %h", c, exc_cause_o, m_cause); end
            vectors++; if (save_cause_o !== m_save) begin miscompares++; $display("FAIL rnd_save cyc %0d got %b want %b", c, save_cause_o, m_save); end
            vectors++; if (in_handler_o !== m_handler) begin miscompares++; $display("FAIL rnd_handler cyc %0d got %b want %b", c, in_handler_o, m_handler); end
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_illegal();
        test_ack_ignored();
        test_simultaneous();
`ifdef EXC_CTRL_IRQ_EN
        test_irq_priority();
        test_preempt();
        test_blocking();
        test_enable_off();
        test_reset_mid();
`else
        test_irq_ignored();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
